// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response,
// decode-side instruction handshake and debug/occupancy observation.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifu_prefetch_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            i_redirect_vld;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvld;
    logic [31:0]     i_imem_rdata;
    logic            o_insn_vld;
    logic [31:0]     o_insn;
    logic [XLEN-1:0] o_insn_pc;
    logic            i_insn_rdy;
    logic [XLEN-1:0] o_pc_debug;
    logic [CW-1:0]   o_buf_count;

    modport master (
        input  i_redirect_vld, i_redirect_pc, i_imem_gnt, i_imem_rvld, i_imem_rdata,
        input  i_insn_rdy,
        output o_imem_req, o_imem_addr, o_insn_vld, o_insn, o_insn_pc, o_pc_debug,
        output o_buf_count
    );

    modport slave (
        output i_redirect_vld, i_redirect_pc, i_imem_gnt, i_imem_rvld, i_imem_rdata,
        output i_insn_rdy,
        input  o_imem_req, o_imem_addr, o_insn_vld, o_insn, o_insn_pc, o_pc_debug,
        input  o_buf_count
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with prefetch FIFO. Issues pipelined in-order fetches,
// buffers returned words with their PCs and hands them to decode. Redirects flush
// the buffer and drop responses to requests already in flight.
// Optional macro IFU_BYPASS_EN: a response arriving while the FIFO is empty is
// presented to decode combinationally in the same cycle.
module ifu_prefetch #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic            i_clk,
    input logic            i_rst_n,
    ifu_prefetch_if.master bus
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);

    logic [XLEN-1:0] f_pc_q, f_pc_d;
    logic [XLEN-1:0] r_pc_q, r_pc_d;
    logic [XLEN-1:0] pc_debug_q, pc_debug_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     insn_mem [DEPTH];

    logic [XLEN-1:0] redirect_tgt;
    logic [CW1-1:0]  credit_used;
    logic            req;
    logic            grant;
    logic            push;
    logic            pop;
    logic            pop_fifo;
    logic            bypass;
    logic            insn_vld;
    logic [XLEN-1:0] insn_pc;
    logic            unused_redirect_lsb;

    assign redirect_tgt        = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^bus.i_redirect_pc[1:0];

    // Request credit: buffered plus in-flight words never exceed the FIFO depth,
    // so every accepted response is guaranteed a free slot.
    always_comb begin
        credit_used = {1'b0, count_q} + {1'b0, outst_q};
        req         = !bus.i_redirect_vld && (credit_used < CW1'(DEPTH));
        grant       = req && bus.i_imem_gnt;
    end

`ifdef IFU_BYPASS_EN
    // Decode-side view: FIFO head, or the live response when the FIFO is empty.
    always_comb begin
        bypass   = (count_q == '0) && (drop_q == '0) && !bus.i_redirect_vld
                   && bus.i_imem_rvld;
        insn_vld = (count_q != '0) || bypass;
        insn_pc  = bypass ? r_pc_q : pc_mem[rd_ptr_q];
        bus.o_insn = bypass ? bus.i_imem_rdata : insn_mem[rd_ptr_q];
    end
`else
    // Decode-side view: FIFO head only, so no path from memory inputs to decode.
    always_comb begin
        bypass     = 1'b0;
        insn_vld   = (count_q != '0);
        insn_pc    = pc_mem[rd_ptr_q];
        bus.o_insn = insn_mem[rd_ptr_q];
    end
`endif

    // Handshake decode; a redirect cancels any pop and any push this cycle.
    always_comb begin
        pop      = insn_vld && bus.i_insn_rdy && !bus.i_redirect_vld;
        pop_fifo = pop && !bypass;
        push     = bus.i_imem_rvld && (drop_q == '0) && !bus.i_redirect_vld
                   && !(bypass && bus.i_insn_rdy);
    end

    // Next-state logic; redirect takes priority over everything else.
    always_comb begin
        f_pc_d     = f_pc_q;
        r_pc_d     = r_pc_q;
        pc_debug_d = pc_debug_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (bus.i_redirect_vld) begin
            f_pc_d   = redirect_tgt;
            r_pc_d   = redirect_tgt;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            // Everything still in flight after this cycle belongs to the old path.
            outst_d  = outst_q - CW'(bus.i_imem_rvld);
            drop_d   = outst_q - CW'(bus.i_imem_rvld);
        end else begin
            if (grant) begin
                f_pc_d = f_pc_q + XLEN'(4);
            end
            outst_d = outst_q + CW'(grant) - CW'(bus.i_imem_rvld);
            if (bus.i_imem_rvld) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    r_pc_d = r_pc_q + XLEN'(4);
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop_fifo);
            if (pop) begin
                pc_debug_d = insn_pc;
            end
        end
    end

    // Control and PC state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_pc_q     <= RESET_PC;
            r_pc_q     <= RESET_PC;
            pc_debug_q <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            f_pc_q     <= f_pc_d;
            r_pc_q     <= r_pc_d;
            pc_debug_q <= pc_debug_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= r_pc_q;
            insn_mem[wr_ptr_q] <= bus.i_imem_rdata;
        end
    end

    assign bus.o_imem_req  = req;
    assign bus.o_imem_addr = f_pc_q;
    assign bus.o_insn_vld  = insn_vld;
    assign bus.o_insn_pc   = insn_pc;
    assign bus.o_pc_debug  = pc_debug_q;
    assign bus.o_buf_count = count_q;
endmodule
